// File: rtl/ccip_rd_requester.sv
// CCI-P channel 0 read initiator: issues num_lines sequential line reads from base_addr under almost-full
// and in-flight limits, forwards each returned line tagged with its index, then pulses done.
module ccip_rd_requester #(
  parameter int ADDR_W          = 42,
  parameter int CNT_W           = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_lines,
  output logic              busy,
  output logic              done,
  output logic              c0_req_valid,
  output logic [ADDR_W-1:0] c0_req_addr,
  output logic [15:0]       c0_req_mdata,
  input  logic              c0_almost_full,
  input  logic              c0_rsp_valid,
  input  logic [15:0]       c0_rsp_mdata,
  input  logic [511:0]      c0_rsp_data,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_idx,
  output logic [511:0]      out_data
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q, issued, received;
  logic [CNT_W-1:0]  issued_nxt, received_nxt;
  logic [OUT_W-1:0]  outstanding;
  logic              fire, rsp_take, busy_nxt;

  assign fire         = (state == ISSUE) && !c0_almost_full && (outstanding < MAX_OUT) && (issued < num_q);
  assign rsp_take     = c0_rsp_valid && ((state == ISSUE) || (state == WAIT));
  assign issued_nxt   = issued + CNT_W'(fire);
  assign received_nxt = received + CNT_W'(rsp_take);

  always_comb begin
    state_nxt = state;
    busy_nxt  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = (num_lines == '0) ? DONE : ISSUE;
      ISSUE:   if (issued_nxt == num_q) state_nxt = (received_nxt == num_q) ? DONE : WAIT;
      WAIT:    if (received_nxt == num_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // busy spans the last forwarded line so it stays high until the done pulse
    busy_nxt = (state_nxt == ISSUE) || (state_nxt == WAIT) || ((state_nxt == DONE) && (state != IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base_q       <= '0;
      num_q        <= '0;
      issued       <= '0;
      received     <= '0;
      outstanding  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      c0_req_valid <= 1'b0;
      c0_req_addr  <= '0;
      c0_req_mdata <= '0;
      out_valid    <= 1'b0;
      out_idx      <= '0;
      out_data     <= '0;
    end else begin
      state        <= state_nxt;
      busy         <= busy_nxt;
      done         <= (state == DONE);
      c0_req_valid <= fire;
      out_valid    <= rsp_take;
      if ((state == IDLE) && start) begin
        base_q      <= base_addr;
        num_q       <= num_lines;
        issued      <= '0;
        received    <= '0;
        outstanding <= '0;
      end else begin
        issued   <= issued_nxt;
        received <= received_nxt;
        if (fire && !rsp_take)
          outstanding <= outstanding + 1'b1;
        else if (!fire && rsp_take && (outstanding != '0))
          outstanding <= outstanding - 1'b1;
      end
      if (fire) begin
        c0_req_addr  <= base_q + ADDR_W'(issued);
        c0_req_mdata <= 16'(issued);
      end
      if (rsp_take) begin
        out_idx  <= c0_rsp_mdata[CNT_W-1:0];
        out_data <= c0_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_ccip_rd_requester.sv
// Bench for ccip_rd_requester: table of directed transfers, reset/abandon sequence and randomized
// transfers, all checked cycle by cycle against a counter/queue model of the request/response rules.
module tb_ccip_rd_requester;
  localparam int AW = 42;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, af, rsp_valid, sel;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_lines;
  logic [15:0]   rsp_mdata;
  logic [511:0]  rsp_data;

  logic a_busy, a_done, a_rv, a_ov, b_busy, b_done, b_rv, b_ov;
  logic [AW-1:0] a_ra, b_ra;
  logic [15:0] a_rm, b_rm;
  logic [CW-1:0] a_oi, b_oi;
  logic [511:0] a_od, b_od;

  logic m_busy, m_done, m_rv, m_ov;
  logic [AW-1:0] m_ra;
  logic [15:0] m_rm;
  logic [CW-1:0] m_oi;
  logic [511:0] m_od;

  ccip_rd_requester #(.ADDR_W(AW), .CNT_W(CW), .MAX_OUTSTANDING(64)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .base_addr(base_addr), .num_lines(num_lines),
    .busy(a_busy), .done(a_done), .c0_req_valid(a_rv), .c0_req_addr(a_ra), .c0_req_mdata(a_rm),
    .c0_almost_full(af), .c0_rsp_valid(rsp_valid & ~sel), .c0_rsp_mdata(rsp_mdata),
    .c0_rsp_data(rsp_data), .out_valid(a_ov), .out_idx(a_oi), .out_data(a_od));

  ccip_rd_requester #(.ADDR_W(AW), .CNT_W(CW), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .base_addr(base_addr), .num_lines(num_lines),
    .busy(b_busy), .done(b_done), .c0_req_valid(b_rv), .c0_req_addr(b_ra), .c0_req_mdata(b_rm),
    .c0_almost_full(af), .c0_rsp_valid(rsp_valid & sel), .c0_rsp_mdata(rsp_mdata),
    .c0_rsp_data(rsp_data), .out_valid(b_ov), .out_idx(b_oi), .out_data(b_od));

  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_rv   = sel ? b_rv   : a_rv;
  assign m_ra   = sel ? b_ra   : a_ra;
  assign m_rm   = sel ? b_rm   : a_rm;
  assign m_ov   = sel ? b_ov   : a_ov;
  assign m_oi   = sel ? b_oi   : a_oi;
  assign m_od   = sel ? b_od   : a_od;

  int vec = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // mode 0: in-order, 2 cycles after request; 1: random order/timing;
  // 2: respond oldest only once issue has stalled 3 cycles; 3: after all issued, order 3,1,0,2
  task automatic run_xfer(input logic s, input logic [AW-1:0] b, input int n, input int af_hold,
                          input bit af_rand, input int mode, input bit noise,
                          output int nreq, output logic [AW-1:0] last_addr);
    int issued, rspd, outs, quiet, budget, maxo, pi;
    bit armed, fin, exp_req, exp_ov;
    int pend[$];
    int due[$];
    int perm[4] = '{3, 1, 0, 2};
    logic [15:0] drv_m;
    logic [511:0] drv_d;
    logic [AW-1:0] ea;
    maxo = s ? 2 : 64;
    sel = s;
    issued = 0; rspd = 0; outs = 0; quiet = 0;
    armed = 0; fin = 0; last_addr = '0;
    drv_m = '0; drv_d = '0;
    budget = 300 + n * 30;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      start     = (cyc == 0) ? 1'b1 : (noise && $urandom_range(3) == 0);
      base_addr = (cyc == 0) ? b : AW'({$urandom, $urandom});
      num_lines = (cyc == 0) ? CW'(n) : CW'($urandom);
      af        = (cyc < af_hold) || (af_rand && $urandom_range(3) == 0);
      exp_req   = (cyc >= 1) && !af && ((issued - rspd) < maxo) && (issued < n);
      pi = -1;
      case (mode)
        0: if (due.size() > 0 && due[0] == cyc) pi = 0;
        1: if (pend.size() > 0 && $urandom_range(1) == 1) pi = int'($urandom_range(pend.size() - 1));
        2: if (pend.size() > 0 && quiet >= 3) pi = 0;
        default: if (issued == n && rspd < 4)
          for (int j = 0; j < pend.size(); j++) if (pend[j] == perm[rspd]) pi = j;
      endcase
      rsp_mdata = 16'($urandom);
      rsp_data  = {16{$urandom}};
      rsp_valid = 1'b0;
      exp_ov    = 1'b0;
      if (pi >= 0) begin
        drv_m = 16'(pend[pi]);
        drv_d = {16{$urandom}} ^ {496'b0, drv_m};
        rsp_valid = 1'b1;
        rsp_mdata = drv_m;
        rsp_data  = drv_d;
        pend.delete(pi);
        due.delete(pi);
        rspd++;
        exp_ov = 1'b1;
      end
      @(posedge clk); #1;
      chk("req_valid", m_rv, exp_req);
      if (m_rv) begin
        ea = b + AW'(issued);
        chk("req_addr", m_ra, ea);
        chk("req_mdata", m_rm, 16'(issued));
        last_addr = m_ra;
        pend.push_back(issued);
        due.push_back(cyc + 3);
        issued++;
        quiet = 0;
      end else begin
        quiet++;
      end
      chk("busy", m_busy, (n != 0) && !armed);
      chk("done", m_done, armed);
      chk("out_valid", m_ov, exp_ov);
      if (exp_ov) begin
        chk("out_idx", m_oi, drv_m[CW-1:0]);
        chk("out_data", m_od, drv_d);
        outs++;
      end
      if (armed) fin = 1;
      else if (outs == n) armed = 1;
    end
    if (!fin) begin
      vec++;
      bad++;
      $display("FAIL xfer_timeout: done not seen, got none expected pulse within %0d cycles", budget);
    end
    start = 1'b0; rsp_valid = 1'b0; af = 1'b0;
    nreq = issued;
  endtask

  typedef struct {
    logic          s;
    logic [AW-1:0] base;
    int            n;
    int            af_hold;
    int            mode;
    int            exp_reqs;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int nr, cnt;
    logic [AW-1:0] la, rb;

    tbl[0] = '{1'b0, 42'h100, 4, 0, 0, 4, 42'h103};
    tbl[1] = '{1'b0, 42'h40, 4, 0, 3, 4, 42'h43};
    tbl[2] = '{1'b1, 42'h80, 5, 0, 2, 5, 42'h84};
    tbl[3] = '{1'b0, 42'h500, 3, 10, 1, 3, 42'h502};
    tbl[4] = '{1'b0, 42'h700, 0, 0, 1, 0, 42'h0};
    tbl[5] = '{1'b0, 42'h3FFFFFFFFFE, 4, 0, 1, 4, 42'h1};
    tbl[6] = '{1'b1, 42'h10, 3, 4, 1, 3, 42'h12};

    rst = 1'b1; start = 1'b0; af = 1'b0; rsp_valid = 1'b0; sel = 1'b0;
    base_addr = '0; num_lines = '0; rsp_mdata = '0; rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_req_valid", a_rv, 1'b0);
    chk("rst_req_addr", a_ra, '0);
    chk("rst_req_mdata", a_rm, '0);
    chk("rst_out_valid", a_ov, 1'b0);
    chk("rst_out_idx", a_oi, '0);
    chk("rst_out_data", a_od, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_xfer(tbl[i].s, tbl[i].base, tbl[i].n, tbl[i].af_hold, 1'b0, tbl[i].mode, 1'b0, nr, la);
      chk("tbl_nreq", nr, tbl[i].exp_reqs);
      chk("tbl_last_addr", la, tbl[i].exp_last);
    end

    // reset mid-transfer, then stale responses must be dropped
    sel = 1'b0; start = 1'b1; base_addr = 42'h200; num_lines = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10 && cnt < 2; k++) begin
      @(posedge clk); #1;
      if (a_rv) cnt++;
    end
    chk("abort_reqs_before_rst", cnt, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", a_busy, 1'b0);
    chk("abort_req_valid", a_rv, 1'b0);
    for (int k = 0; k < 5; k++) begin
      rsp_valid = (k < 2);
      rsp_mdata = 16'(k);
      rsp_data  = {16{$urandom}};
      @(posedge clk); #1;
      chk("stale_out_valid", a_ov, 1'b0);
      chk("stale_done", a_done, 1'b0);
      chk("stale_req_valid", a_rv, 1'b0);
    end
    rsp_valid = 1'b0;
    run_xfer(1'b0, 42'h300, 1, 0, 1'b0, 1, 1'b0, nr, la);
    chk("after_abort_nreq", nr, 1);
    chk("after_abort_addr", la, 42'h300);

    for (int i = 0; i < 8; i++) begin
      rb = '1;
      rb = ($urandom_range(2) == 0) ? rb - AW'($urandom_range(8)) : AW'({$urandom, $urandom});
      cnt = int'($urandom_range(1, 24));
      run_xfer(1'($urandom_range(1)), rb, cnt, int'($urandom_range(3)), 1'b1, 1, 1'b1, nr, la);
      chk("rand_nreq", nr, cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
